// File: rtl/fetch_controller.sv
// fetch_controller: instruction-fetch sequencer owning the PC and the IF/ID register.
// Fetches one word per cycle, honours stalls and branch redirects, and halts
// when the PC leaves the program image or an all-zero word is read.
module fetch_controller #(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned INSTR_W    = 32,
  parameter int unsigned IMEM_BYTES = 226
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic               if_id_valid,
  output logic               halted,
  output logic [31:0]        fetch_count
);

  localparam int unsigned CNT_W = 32;
  // Highest PC that still fits a whole word; any pc above it is past the image.
  localparam logic [ADDR_W-1:0] LAST_FETCH = ADDR_W'(IMEM_BYTES - 4);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  if_id_pc_q, if_id_pc_d;
  logic [INSTR_W-1:0] if_id_instr_q, if_id_instr_d;
  logic               if_id_valid_q, if_id_valid_d;
  logic               halted_q, halted_d;
  logic [CNT_W-1:0]   fetch_count_q, fetch_count_d;

  logic [ADDR_W-1:0]  target_aligned;
  logic               end_of_prog;

  // Redirect target forced to word alignment; end test uses the unwrapped bound.
  always_comb begin
    target_aligned = branch_target & ~ADDR_W'(3);
    end_of_prog    = (pc_q > LAST_FETCH) || (imem_data == '0);
  end

  // Next-state and next-output computation for the fetch sequencer.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    halted_d      = halted_q;
    fetch_count_d = fetch_count_q;

    unique case (state_q)
      S_IDLE: begin
        state_d       = S_RUN;
        if_id_valid_d = 1'b0;
      end
      S_RUN: begin
        if (branch_taken) begin
          pc_d          = target_aligned;
          if_id_valid_d = 1'b0;
          if_id_instr_d = '0;
        end else if (stall) begin
          // hold everything
        end else if (end_of_prog) begin
          state_d       = S_HALT;
          halted_d      = 1'b1;
          if_id_valid_d = 1'b0;
        end else begin
          if_id_instr_d = imem_data;
          if_id_pc_d    = pc_q;
          if_id_valid_d = 1'b1;
          pc_d          = pc_q + ADDR_W'(4);
          fetch_count_d = (fetch_count_q == '1) ? fetch_count_q
                                                : fetch_count_q + CNT_W'(1);
        end
      end
      S_HALT: begin
        if_id_valid_d = 1'b0;
        if (branch_taken) begin
          pc_d     = target_aligned;
          state_d  = S_RUN;
          halted_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      if_id_pc_q    <= '0;
      if_id_instr_q <= '0;
      if_id_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_valid = if_id_valid_q;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed bench with a capture scoreboard for fetch_controller.
module tb_fetch_controller;

  localparam int unsigned ADDR_W     = 64;
  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned IMEM_BYTES = 226;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               stall;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_target;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [ADDR_W-1:0]  if_id_pc;
  logic [INSTR_W-1:0] if_id_instr;
  logic               if_id_valid;
  logic               halted;
  logic [31:0]        fetch_count;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [31:0] prev_count = '0;
  logic [31:0] saved_count;
  logic [INSTR_W-1:0] prog [10] = '{
    32'hF8428005, 32'hF845000A, 32'h8A0A00A1, 32'hAA0A00A2, 32'h8B0A00A3,
    32'hCB0A00A4, 32'hF8008001, 32'hF8010002, 32'hF8018003, 32'hF8020004};

  fetch_controller #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .IMEM_BYTES(IMEM_BYTES)
  ) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
    .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Combinational instruction memory: program at 0..39, a nonzero word at 224.
  always_comb begin
    if (imem_addr < 64'd40)       imem_data = prog[imem_addr[5:2]];
    else if (imem_addr == 64'd224) imem_data = 32'hDEADBEEF;
    else                          imem_data = '0;
  end

  task automatic check(input string tag, input logic [ADDR_W-1:0] obs,
                       input logic [ADDR_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [ADDR_W-1:0] a);
    exp_t e;
    e.pc    = a;
    e.instr = prog[a[5:2]];
    sb.push_back(e);
  endtask

  // One clock; a new capture (valid with fetch_count advanced) pops the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (if_id_valid && fetch_count != prev_count) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_capture: observed pc %0h expected none", if_id_pc);
      end else begin
        e = sb.pop_front();
        check("capture_pc", if_id_pc, e.pc);
        check("capture_instr", 64'(if_id_instr), 64'(e.instr));
      end
    end
    prev_count = fetch_count;
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    tick(); tick();
    check("rst_addr", imem_addr, 64'd0);
    check("rst_valid", 64'(if_id_valid), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_count", 64'(fetch_count), 64'd0);
    check("rst_instr", 64'(if_id_instr), 64'd0);
    check("rst_pc", if_id_pc, 64'd0);

    // Program run
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) push(64'(4 * i));
    tick();
    check("idle_no_capture", 64'(if_id_valid), 64'd0);
    for (int i = 0; i < 10; i++) tick();
    check("prog_count", 64'(fetch_count), 64'd10);
    check("prog_not_halted_yet", 64'(halted), 64'd0);
    tick();
    check("prog_halted", 64'(halted), 64'd1);
    check("prog_halt_valid", 64'(if_id_valid), 64'd0);
    check("prog_halt_count", 64'(fetch_count), 64'd10);
    check("prog_halt_pc", imem_addr, 64'd40);
    check("prog_sb_empty", 64'(sb.size()), 64'd0);
    stall = 1'b1;
    tick();
    check("halt_stall_ignored", 64'(halted), 64'd1);
    stall = 1'b0;

    // Stall: branch back to 0 from HALT, fetch up to if_id_pc=8, then stall 3
    branch_taken = 1'b1; branch_target = 64'd0;
    tick();
    check("unhalt_halted", 64'(halted), 64'd0);
    check("unhalt_pc", imem_addr, 64'd0);
    branch_taken = 1'b0;
    push(0); push(4); push(8);
    tick(); tick(); tick();
    check("pre_stall_pc", if_id_pc, 64'd8);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_if_id_pc", if_id_pc, 64'd8);
      check("stall_instr", 64'(if_id_instr), 64'h8A0A00A1);
      check("stall_addr", imem_addr, 64'd12);
      check("stall_count", 64'(fetch_count), 64'd13);
    end
    stall = 1'b0;
    push(12);
    tick();
    check("post_stall_count", 64'(fetch_count), 64'd14);

    // Branch with misaligned target 0x1B while pc=0x10
    check("pre_branch_addr", imem_addr, 64'h10);
    branch_taken = 1'b1; branch_target = 64'h1B;
    tick();
    check("branch_addr", imem_addr, 64'h18);
    check("branch_bubble", 64'(if_id_valid), 64'd0);
    branch_taken = 1'b0;
    push(64'h18);
    tick();

    // Branch and stall in the same cycle: branch wins
    stall = 1'b1; branch_taken = 1'b1; branch_target = 64'h04;
    tick();
    check("bs_addr", imem_addr, 64'h04);
    check("bs_bubble", 64'(if_id_valid), 64'd0);
    check("bs_instr_cleared", 64'(if_id_instr), 64'd0);
    stall = 1'b0; branch_taken = 1'b0;
    push(4);
    tick();

    // Bound halt at 224 with nonzero data
    branch_taken = 1'b1; branch_target = 64'd224;
    tick();
    check("bound_addr", imem_addr, 64'd224);
    check("bound_bubble", 64'(if_id_valid), 64'd0);
    saved_count = fetch_count;
    branch_taken = 1'b0;
    tick();
    check("bound_halted", 64'(halted), 64'd1);
    check("bound_valid", 64'(if_id_valid), 64'd0);
    check("bound_pc_hold", imem_addr, 64'd224);
    check("bound_no_count", 64'(fetch_count), 64'(saved_count));
    branch_taken = 1'b1; branch_target = 64'd0;
    tick();
    check("rerun_halted", 64'(halted), 64'd0);
    branch_taken = 1'b0;
    push(0);
    tick();

    // Reset mid-run at pc=0x14
    push(4); push(8); push(12); push(16);
    tick(); tick(); tick(); tick();
    check("pre_reset_addr", imem_addr, 64'h14);
    reset_n = 1'b0;
    tick();
    check("mid_rst_addr", imem_addr, 64'd0);
    check("mid_rst_valid", 64'(if_id_valid), 64'd0);
    check("mid_rst_count", 64'(fetch_count), 64'd0);
    check("mid_rst_halted", 64'(halted), 64'd0);
    reset_n = 1'b1;
    push(0); push(4);
    tick();
    check("restart_idle", 64'(if_id_valid), 64'd0);
    tick(); tick();
    check("restart_count", 64'(fetch_count), 64'd2);
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
